// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-memory and engine handshake bundle for the sequencer.
interface instr_sequencer_if #(parameter int PC_W = 8);
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            imem_valid;
  logic [3:0]      eng_start;
  logic [3:0]      eng_done;
  modport master (output imem_rd, imem_addr, eng_start, input imem_data, imem_valid, eng_done);
  modport slave  (input imem_rd, imem_addr, eng_start, output imem_data, imem_valid, eng_done);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/dispatch sequencer driving four execution engines with a done timeout.
module instr_sequencer #(
  parameter int PC_W = 8,
  parameter int TMO  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                clear,
  instr_sequencer_if.master   bus,
  output logic [3:0]          opcode,
  output logic [5:0]          ri,
  output logic [5:0]          rj,
  output logic                busy,
  output logic                halted,
  output logic [1:0]          err
);
  localparam int CW = $clog2(TMO + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_I, DECODE, START, WAIT_D, NEXT, HALT} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      sel_q, sel_d, start_q, start_d, op, dec_sel;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;
  logic            rd_q, rd_d, busy_q, busy_d, halted_q, halted_d;
  assign op      = ir_q[15:12];
  assign dec_sel = op == 4'h1 ? 4'b0001 :
                   op == 4'h2 ? 4'b0010 :
                   op == 4'h7 ? 4'b1000 :
                   (op >= 4'h3 && op <= 4'h6) ? 4'b0100 : 4'b0000;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE:    state_d = run ? FETCH : IDLE;
      FETCH:   state_d = WAIT_I;
      WAIT_I:  if (bus.imem_valid) begin
        ir_d    = bus.imem_data;
        state_d = DECODE;
      end
      DECODE: begin
        sel_d   = dec_sel;
        state_d = op == 4'h0 ? NEXT : dec_sel != 4'b0000 ? START : HALT;
        err_d   = (op[3] && op != 4'hF) ? 2'b01 : err_q;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_D;
      end
      WAIT_D: begin
        cnt_d = cnt_q + 1'b1;
        if (|(bus.eng_done & sel_q)) state_d = NEXT;
        else if (cnt_d == CW'(TMO)) begin
          err_d   = 2'b10;
          state_d = HALT;
        end
      end
      NEXT: begin
        pc_d    = pc_q + 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      default: ;
    endcase
    if (clear) begin
      state_d = IDLE;
      pc_d    = '0;
      err_d   = '0;
    end
    // outputs are registered from the next state so they line up with the state they describe
    rd_d     = state_d == FETCH;
    start_d  = state_d == START ? sel_d : 4'b0000;
    busy_d   = !(state_d == IDLE || state_d == HALT);
    halted_d = state_d == HALT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      rd_q     <= 1'b0;
      start_q  <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end
  assign bus.imem_rd   = rd_q;
  assign bus.imem_addr = pc_q;
  assign bus.eng_start = start_q;
  assign opcode        = ir_q[15:12];
  assign ri            = ir_q[11:6];
  assign rj            = ir_q[5:0];
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign err           = err_q;
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 The block SHALL have parameter TMO, default 64, the maximum cycles allowed between an engine start pulse and its done.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 run  in  1  level; 1 permits fetching, 0 pauses at the next instruction boundary.
REQ-006 clear  in  1  synchronous pulse; sets pc to 0 and clears halted and err.
REQ-007 imem_rd  out  1  one-cycle instruction read strobe.
REQ-008 imem_addr  out  PC_W  instruction address, equal to pc.
REQ-009 imem_data  in  16  instruction word, sampled when imem_valid=1.
REQ-010 imem_valid  in  1  instruction memory response strobe.
REQ-011 eng_start  out  4  one-hot start pulse: bit0 MOV, bit1 MOVI, bit2 ALU, bit3 ALUI.
REQ-012 eng_done  in  4  per-engine done, indexed as eng_start.
REQ-013 opcode  out  4  ir[15:12]; ri  out  6  ir[11:6]; rj  out  6  ir[5:0]; all held stable from DECODE until the next FETCH.
REQ-014 busy  out  1  1 in every state except IDLE and HALT.
REQ-015 halted  out  1  1 in HALT.
REQ-016 err  out  2  00 none, 01 illegal opcode, 10 engine timeout; sticky until clear or reset.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, WAIT_I, DECODE, START, WAIT_D, NEXT and HALT.
REQ-018 IDLE: the block SHALL go to FETCH when run=1 and stay in IDLE otherwise.
REQ-019 FETCH: the block SHALL drive imem_rd=1 for exactly one cycle with imem_addr=pc, then go to WAIT_I.
REQ-020 WAIT_I: the block SHALL latch imem_data into ir and go to DECODE on the cycle imem_valid=1, and wait with no limit otherwise; imem_valid outside WAIT_I SHALL be ignored.
REQ-021 DECODE: the block SHALL decode as follows: 0x0 NOP goes to NEXT; 0x1 selects engine 0; 0x2 selects engine 1; 0x3-0x6 select engine 2; 0x7 selects engine 3; 0xF HALT goes to HALT; 0x8-0xE set err=01 and go to HALT.
REQ-022 START: the block SHALL assert exactly one eng_start bit for exactly one cycle, clear the timeout counter, and go to WAIT_D.
REQ-023 WAIT_D: the block SHALL go to NEXT on the first cycle the selected eng_done bit is 1; done bits of non-selected engines SHALL be ignored.
REQ-024 WAIT_D: the timeout counter SHALL increment each cycle; when it reaches TMO without done, the block SHALL set err=10 and go to HALT.
REQ-025 NEXT: the block SHALL set pc<=pc+1 modulo 2^PC_W (all-ones wraps to 0), then go to FETCH if run=1 and to IDLE otherwise.
REQ-026 Deasserting run mid-instruction SHALL NOT abort the instruction; the pause takes effect at NEXT.
REQ-027 HALT: the block SHALL stay in HALT with pc unchanged until clear.
REQ-028 clear in any state SHALL set pc=0, err=00, drop eng_start and imem_rd, and go to IDLE, taking priority over all other transitions.
REQ-029 Minimum latency per instruction, with imem_valid one cycle after imem_rd and done one cycle after start: FETCH, WAIT_I, DECODE, START, WAIT_D, NEXT = 6 cycles; a NOP takes 4 cycles.

Reset
REQ-030 While reset=1, the block SHALL asynchronously force state=IDLE, pc=0, ir=0, timeout counter=0 and all outputs to 0, including err=00.
REQ-031 Reset mid-operation SHALL drop any eng_start or imem_rd immediately, without waiting for a clock edge.

Verification
REQ-032 run=1 with program {0x1042, 0x7083, 0xF000} and each done returned 2 cycles after start -> eng_start pulses 0001 then 1000; ri/rj are 1/2 then 2/3; halted=1 with pc=2.
REQ-033 Instruction word 0x9000 at pc=0 -> err=01, halted=1, and no eng_start pulse.
REQ-034 ALU instruction fetched with eng_done held 0 -> err=10 exactly TMO cycles after the START cycle, then halted=1.
REQ-035 pc=255 with a NOP fetched -> next imem_addr=0.
REQ-036 run dropped during WAIT_D -> the instruction completes, the block enters IDLE with pc incremented, and reasserting run resumes at the new pc.
REQ-037 reset pulsed during WAIT_D, and separately clear pulsed in HALT -> all outputs 0 and state IDLE in both cases; engine done arriving after the reset is ignored.
